hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/wisc_pkg.sv | 13 +
 rtl/hazard_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared pipeline-control definitions: register-number width and the
// hazard controller's state encoding.
package wisc_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hc_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the Decode instruction reads a register
// that the load currently in Execute has not yet produced.
module hazard_detect
    import wisc_pkg::*;
(
    input  logic [REG_W-1:0] id_srcReg1,
    input  logic [REG_W-1:0] id_srcReg2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic [REG_W-1:0] ex_dstReg,
    input  logic             ex_memRead,
    output logic             load_use_o
);

    logic src1_hit;
    logic src2_hit;

    assign src1_hit = id_uses_src1 && (id_srcReg1 == ex_dstReg);
    assign src2_hit = id_uses_src2 && (id_srcReg2 == ex_dstReg);

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use_o = ex_memRead && (ex_dstReg != '0) && (src1_hit || src2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freezes on memory busy, flushes on taken branch,
// stalls on load-use, and drains the pipeline after HLT before halting.
module hazard_ctrl
    import wisc_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_srcReg1,
    input  logic [REG_W-1:0] id_srcReg2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             id_is_hlt,
    input  logic [REG_W-1:0] ex_dstReg,
    input  logic             ex_memRead,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_wen,
    output logic             if_id_wen,
    output logic             id_ex_wen,
    output logic             ex_mem_wen,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             load_use;
    hc_state_e        state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    hazard_detect u_detect (
        .id_srcReg1   (id_srcReg1),
        .id_srcReg2   (id_srcReg2),
        .id_uses_src1 (id_uses_src1),
        .id_uses_src2 (id_uses_src2),
        .ex_dstReg    (ex_dstReg),
        .ex_memRead   (ex_memRead),
        .load_use_o   (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        stall_d     = stall_q;
        pc_wen      = 1'b1;
        if_id_wen   = 1'b1;
        id_ex_wen   = 1'b1;
        ex_mem_wen  = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (state_q == ST_HALTED || mem_busy) begin
            pc_wen     = 1'b0;
            if_id_wen  = 1'b0;
            id_ex_wen  = 1'b0;
            ex_mem_wen = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_wen      = 1'b0;
                        if_id_wen   = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_d     = (&stall_q) ? stall_q : stall_q + CNT_ONE;
                    end else if (id_is_hlt) begin
                        pc_wen      = 1'b0;
                        if_id_flush = 1'b1;
                        drain_d     = DRAIN_INIT;
                        state_d     = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A taken branch means the HLT was fetched down the wrong path.
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        drain_d     = '0;
                        state_d     = ST_RUN;
                    end else begin
                        pc_wen      = 1'b0;
                        if_id_flush = 1'b1;
                        drain_d     = drain_q - 3'd1;
                        if (drain_q <= 3'd1) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign halted      = (state_q == ST_HALTED);
    assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all checked against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int D     = 3;
    localparam int CW    = 4;
    localparam int MAXC  = 15;

    logic       clk;
    logic       rst_n;
    logic [3:0] id_srcReg1, id_srcReg2, ex_dstReg;
    logic       id_uses_src1, id_uses_src2, id_is_hlt;
    logic       ex_memRead, ex_branch_taken, mem_busy;
    logic       pc_wen, if_id_wen, id_ex_wen, ex_mem_wen;
    logic       if_id_flush, id_ex_flush, halted;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles of drain left (0 = not draining), halt flag, stall total.
    int m_drain;
    bit m_halt;
    int m_stalls;

    hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_srcReg1      (id_srcReg1),
        .id_srcReg2      (id_srcReg2),
        .id_uses_src1    (id_uses_src1),
        .id_uses_src2    (id_uses_src2),
        .id_is_hlt       (id_is_hlt),
        .ex_dstReg       (ex_dstReg),
        .ex_memRead      (ex_memRead),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_wen          (pc_wen),
        .if_id_wen       (if_id_wen),
        .id_ex_wen       (id_ex_wen),
        .ex_mem_wen      (ex_mem_wen),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .halted          (halted),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, if_id_flush, id_ex_flush, halted};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input logic busy, input logic br, input logic mr, input logic [3:0] dst,
                          input logic [3:0] s1, input logic [3:0] s2,
                          input logic u1, input logic u2, input logic hlt);
        mem_busy = busy; ex_branch_taken = br; ex_memRead = mr; ex_dstReg = dst;
        id_srcReg1 = s1; id_srcReg2 = s2; id_uses_src1 = u1; id_uses_src2 = u2; id_is_hlt = hlt;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input string tag, input logic busy, input logic br, input logic mr,
                        input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                        input logic u1, input logic u2, input logic hlt);
        logic [6:0] e;
        int  nd, ns;
        bit  nh, lu;
        set_in(busy, br, mr, dst, s1, s2, u1, u2, hlt);
        lu = mr && (dst != 0) && ((u1 && s1 == dst) || (u2 && s2 == dst));
        nd = m_drain; nh = m_halt; ns = m_stalls;
        // vector order: pc, if_id, id_ex, ex_mem wen; if_id, id_ex flush; halted
        if (m_halt)               e = 7'b0000_00_1;
        else if (busy)            e = 7'b0000_00_0;
        else if (br) begin        e = 7'b1111_11_0; nd = 0; end
        else if (m_drain > 0) begin
                                  e = 7'b0111_10_0; nd = m_drain - 1;
                                  if (nd == 0) nh = 1;
        end
        else if (lu) begin        e = 7'b0011_01_0; ns = (m_stalls < MAXC) ? m_stalls + 1 : MAXC; end
        else if (hlt) begin       e = 7'b0111_10_0; nd = D; end
        else                      e = 7'b1111_00_0;
        @(negedge clk);
        chk({tag, ".outs"}, 16'(outs()), 16'(e));
        @(posedge clk);
        #1;
        m_drain = nd; m_halt = nh; m_stalls = ns;
        chk({tag, ".stall_count"}, 16'(stall_count), 16'(m_stalls));
        chk({tag, ".halted"}, 16'(halted), 16'(m_halt));
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
    endtask

    // Asserts reset away from any edge, checks its immediate effect, releases at posedge+1.
    task automatic do_reset(input string tag);
        set_in(0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        m_drain = 0; m_halt = 0; m_stalls = 0;
        chk({tag, ".rst_stall"}, 16'(stall_count), 16'd0);
        chk({tag, ".rst_outs"}, 16'(outs()), 16'(7'b1111_00_0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        m_drain = 0; m_halt = 0; m_stalls = 0;
        do_reset("init");
        idle("idle0");

        // Load-use on src1, then the same with r0 as destination, then src2.
        step("lu_src1", 0, 0, 1, 4'd5, 4'd5, 4'd0, 1, 0, 0);
        chk("lu_src1.count", 16'(stall_count), 16'd1);
        step("lu_r0", 0, 0, 1, 4'd0, 4'd0, 4'd0, 1, 1, 0);
        step("lu_src2", 0, 0, 1, 4'd7, 4'd1, 4'd7, 0, 1, 0);
        step("lu_unused", 0, 0, 1, 4'd7, 4'd7, 4'd7, 0, 0, 0);
        step("lu_br", 0, 1, 1, 4'd5, 4'd5, 4'd0, 1, 0, 0);
        step("busy_lu", 1, 0, 1, 4'd5, 4'd5, 4'd0, 1, 0, 0);
        chk("count_after_mix", 16'(stall_count), 16'd2);

        // HLT with two frozen cycles inside DRAIN.
        step("hlt", 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1);
        idle("drain1");
        step("drain_busy1", 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        step("drain_busy2", 1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        idle("drain2");
        chk("not_yet_halted", 16'(halted), 16'd0);
        idle("drain3");
        chk("halted_late", 16'(halted), 16'd1);
        step("halt_ignores", 0, 1, 1, 4'd3, 4'd3, 4'd3, 1, 1, 1);
        do_reset("rst_halted");
        idle("post_rst");

        // HLT on the wrong path: branch on the second DRAIN cycle.
        step("hlt2", 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1);
        idle("d2_1");
        step("d2_br", 0, 1, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle("d2_after");
        chk("never_halted", 16'(halted), 16'd0);

        // Saturation then async reset mid-DRAIN.
        for (int i = 0; i < 20; i++) step("sat", 0, 0, 1, 4'd9, 4'd2, 4'd9, 1, 1, 0);
        chk("saturated", 16'(stall_count), 16'(MAXC));
        step("hlt3", 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1);
        idle("d3_1");
        do_reset("rst_drain");
        idle("post_rst2");

        // Random traffic; reset a few cycles after each halt.
        begin
            int halt_cycles = 0;
            for (int i = 0; i < 400; i++) begin
                logic [3:0] dst, s1, s2;
                dst = 4'($urandom_range(0, 3));
                s1  = 4'($urandom_range(0, 3));
                s2  = 4'($urandom_range(0, 3));
                step("rand",
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) == 0, dst, s1, s2,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 15) == 0);
                halt_cycles = m_halt ? halt_cycles + 1 : 0;
                if (halt_cycles > 3) begin
                    do_reset("rand_rst");
                    halt_cycles = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
